// File: rtl/modport_slave_if.sv
// Bus interface for modport_slave: select/enable two-phase handshake,
// word address, write data, and read data / ready / error responses.
interface modport_slave_if;
    logic        sel;
    logic        en;
    logic [16:0] addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;
    logic        slv_err;

    modport master (
        output sel,
        output en,
        output addr,
        output wr_en,
        output wr_data,
        input  rd_data,
        input  ready,
        input  slv_err
    );

    modport slave (
        input  sel,
        input  en,
        input  addr,
        input  wr_en,
        input  wr_data,
        output rd_data,
        output ready,
        output slv_err
    );
endinterface

// File: rtl/modport_slave.sv
// modport_slave: word-addressed storage of DEPTH 32-bit words behind a
// select/enable handshake (IDLE -> SETUP -> ACCESS).
// Reads are registered at the SETUP->ACCESS edge so data is ready in the
// first access cycle. Addresses at or above DEPTH raise slv_err and never
// touch storage. Reset clears the FSM, outputs and every storage word.
// Optional build macro: MODPORT_SLAVE_WAIT_EN inserts exactly one wait
// cycle (ready=0) at the start of every access phase.
module modport_slave #(
    parameter int DEPTH = 256
) (
    input  logic           clk,
    input  logic           reset,
    modport_slave_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    // state_q is the registered FSM state. state is the state of the
    // current cycle: a registered IDLE that sees sel=1,en=0 on the bus is
    // already the SETUP cycle, which is what makes reads zero-wait and lets
    // a completed access flow straight into the next setup cycle.
    state_e        state_q;
    state_e        state;
    state_e        next_state;

    logic [AW-1:0] idx_q;
    logic          wr_q;
    logic          valid_q;
    logic          addr_ok;
    logic          ready_int;
    logic          complete;
    logic [31:0]   rd_data_q;
    logic [31:0]   mem [DEPTH];

`ifdef MODPORT_SLAVE_WAIT_EN
    logic wait_q;
    assign ready_int = wait_q;
`else
    assign ready_int = 1'b1;
`endif

    // Address is in range when no bit at or above log2(DEPTH) is set.
    assign addr_ok = (bus.addr[16:AW] == '0);

    assign bus.ready   = (state == ACCESS) && ready_int;
    assign bus.slv_err = (state == ACCESS) && ready_int && !valid_q;
    assign bus.rd_data = rd_data_q;

    // Current-state resolution and next-state decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state      = state_q;
        next_state = state_q;
        complete   = 1'b0;
        case (state_q)
            IDLE: begin
                // sel=1,en=1 without a setup cycle is ignored.
                if (bus.sel && !bus.en) begin
                    state      = SETUP;
                    next_state = ACCESS;
                end else begin
                    next_state = IDLE;
                end
            end
            ACCESS: begin
                if (!bus.sel) begin
                    // Master dropped sel: abort, nothing is written.
                    next_state = IDLE;
                end else if (bus.en && ready_int) begin
                    // Completed. Returning to IDLE lets a following
                    // sel=1,en=0 cycle be taken directly as SETUP.
                    complete   = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = ACCESS;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values whatever the block order.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Latch index, direction and address validity in the setup cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            valid_q <= 1'b0;
        end else if (state == SETUP) begin
            idx_q   <= bus.addr[AW-1:0];
            wr_q    <= bus.wr_en;
            valid_q <= addr_ok;
        end
    end

    // Register read data at the SETUP->ACCESS edge; hold it otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (state == SETUP && !bus.wr_en) begin
            rd_data_q <= addr_ok ? mem[bus.addr[AW-1:0]] : '0;
        end
    end

    // Storage: written only on a completing access to a valid address.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: storage must clear on reset, so it is a resettable flop array; a plain RAM cannot be cleared in one reset.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (complete && wr_q && valid_q) begin
            mem[idx_q] <= bus.wr_data;
        end
    end

`ifdef MODPORT_SLAVE_WAIT_EN
    // Wait flag: low in the first access cycle, high from the second on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= 1'b0;
        end else begin
            wait_q <= (state == ACCESS) && bus.sel && !complete;
        end
    end
`endif

endmodule

// File: tb/tb_modport_slave.sv
// Self-checking bench for modport_slave (DEPTH=256). A word-array model of
// the storage predicts read data, error flag and access latency.
// Build with MODPORT_SLAVE_WAIT_EN defined to expect one wait cycle per access.
module tb_modport_slave;

    localparam int DEPTH = 256;
`ifdef MODPORT_SLAVE_WAIT_EN
    localparam int EXP_WAITS = 1;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    modport_slave_if bus ();

    modport_slave #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_rd = '0;
    endfunction

    // One completed transfer: expected rd_data and slv_err, model updated.
    function automatic void model_xfer(input logic wr, input logic [16:0] a,
                                       input logic [31:0] d,
                                       output logic [31:0] exp_rd,
                                       output logic exp_err);
        bit valid;
        valid   = (int'(a) < DEPTH);
        exp_err = !valid;
        if (!wr) model_rd = valid ? model_mem[int'(a)] : 32'h0;
        else if (valid) model_mem[int'(a)] = d;
        exp_rd = model_rd;
    endfunction

    // Drive one setup+access transfer; returns sampled response values.
    task automatic xfer(input logic wr, input logic [16:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic err,
                        output int waits, output logic setup_clean);
        @(negedge clk);
        bus.sel = 1'b1; bus.en = 1'b0; bus.addr = a; bus.wr_en = wr; bus.wr_data = d;
        #1 setup_clean = (bus.ready === 1'b0) && (bus.slv_err === 1'b0);
        @(negedge clk);
        bus.en = 1'b1;
        waits = 0; rd = 'x; err = 'x;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.ready === 1'b1) begin
                rd  = bus.rd_data;
                err = bus.slv_err;
                break;
            end
            waits++;
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.sel = 1'b0; bus.en = 1'b0; bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sel = 1'b0; bus.en = 1'b0; bus.addr = '0; bus.wr_en = 1'b0; bus.wr_data = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", bus.ready); end
        checks++; if (bus.slv_err !== 1'b0) begin failures++; $display("FAIL reset_slv_err got %b want 0", bus.slv_err); end
        checks++; if (bus.rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_first_read();
        logic [31:0] rd, exp_rd; logic err, exp_err, sc; int w;
        xfer(1'b0, 17'h00005, 32'h0, rd, err, w, sc);
        model_xfer(1'b0, 17'h00005, 32'h0, exp_rd, exp_err);
        checks++; if (!sc) begin failures++; $display("FAIL first_read_setup ready/slv_err got %b/%b want 0/0", bus.ready, bus.slv_err); end
        checks++; if (w !== EXP_WAITS) begin failures++; $display("FAIL first_read_waits got %0d want %0d", w, EXP_WAITS); end
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL first_read_data got %h want %h", rd, exp_rd); end
        checks++; if (err !== exp_err) begin failures++; $display("FAIL first_read_err got %b want %b", err, exp_err); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, exp_rd, d; logic err, exp_err, sc; int w; logic [16:0] a;
        xfer(1'b1, 17'h00010, 32'hDEADBEEF, rd, err, w, sc);
        model_xfer(1'b1, 17'h00010, 32'hDEADBEEF, exp_rd, exp_err);
        xfer(1'b0, 17'h00010, 32'h0, rd, err, w, sc);
        model_xfer(1'b0, 17'h00010, 32'h0, exp_rd, exp_err);
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL b2b_deadbeef got %h want %h", rd, exp_rd); end
        checks++; if (!sc) begin failures++; $display("FAIL b2b_setup not clean after completion"); end
        for (int i = 0; i < 6; i++) begin
            a = 17'($urandom_range(0, 31));
            d = $urandom;
            xfer(1'b1, a, d, rd, err, w, sc);
            model_xfer(1'b1, a, d, exp_rd, exp_err);
            checks++; if (rd !== exp_rd) begin failures++; $display("FAIL b2b_write_hold[%0d] got %h want %h", i, rd, exp_rd); end
            xfer(1'b0, a, 32'h0, rd, err, w, sc);
            model_xfer(1'b0, a, 32'h0, exp_rd, exp_err);
            checks++; if (rd !== exp_rd) begin failures++; $display("FAIL b2b_raw[%0d] addr %h got %h want %h", i, a, rd, exp_rd); end
        end
        idle();
    endtask

    task automatic test_invalid();
        logic [31:0] rd, exp_rd; logic err, exp_err, sc; int w;
        xfer(1'b1, 17'h00000, 32'h0BADF00D, rd, err, w, sc);
        model_xfer(1'b1, 17'h00000, 32'h0BADF00D, exp_rd, exp_err);
        checks++; if (err !== exp_err) begin failures++; $display("FAIL inv_valid_write_err got %b want %b", err, exp_err); end
        xfer(1'b1, 17'h00100, 32'h12345678, rd, err, w, sc);
        model_xfer(1'b1, 17'h00100, 32'h12345678, exp_rd, exp_err);
        checks++; if (err !== exp_err) begin failures++; $display("FAIL inv_write_err got %b want %b", err, exp_err); end
        checks++; if (w !== EXP_WAITS) begin failures++; $display("FAIL inv_write_waits got %0d want %0d", w, EXP_WAITS); end
        idle();
        xfer(1'b0, 17'h00000, 32'h0, rd, err, w, sc);
        model_xfer(1'b0, 17'h00000, 32'h0, exp_rd, exp_err);
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL inv_addr0_unchanged got %h want %h", rd, exp_rd); end
        xfer(1'b0, 17'h1ABCD, 32'h0, rd, err, w, sc);
        model_xfer(1'b0, 17'h1ABCD, 32'h0, exp_rd, exp_err);
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL inv_read_data got %h want %h", rd, exp_rd); end
        checks++; if (err !== exp_err) begin failures++; $display("FAIL inv_read_err got %b want %b", err, exp_err); end
        idle();
        #1;
        checks++; if (bus.slv_err !== 1'b0) begin failures++; $display("FAIL inv_err_outside_access got %b want 0", bus.slv_err); end
    endtask

    task automatic test_protocol_violation();
        logic [31:0] rd, exp_rd; logic err, exp_err, sc; int w;
        xfer(1'b1, 17'h00007, 32'h11112222, rd, err, w, sc);
        model_xfer(1'b1, 17'h00007, 32'h11112222, exp_rd, exp_err);
        idle();
        @(negedge clk);
        bus.sel = 1'b1; bus.en = 1'b1; bus.wr_en = 1'b1; bus.addr = 17'h00007; bus.wr_data = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL viol_ready[%0d] got %b want 0", i, bus.ready); end
            @(negedge clk);
        end
        bus.sel = 1'b0; bus.en = 1'b0; bus.wr_en = 1'b0;
        xfer(1'b0, 17'h00007, 32'h0, rd, err, w, sc);
        model_xfer(1'b0, 17'h00007, 32'h0, exp_rd, exp_err);
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL viol_no_write got %h want %h", rd, exp_rd); end
        idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd, exp_rd; logic err, exp_err, sc; int w;
        xfer(1'b1, 17'h00009, 32'h55667788, rd, err, w, sc);
        model_xfer(1'b1, 17'h00009, 32'h55667788, exp_rd, exp_err);
        idle();
        @(negedge clk);
        bus.sel = 1'b1; bus.en = 1'b0; bus.addr = 17'h00009; bus.wr_en = 1'b1; bus.wr_data = 32'hFFFF0000;
        @(negedge clk);
        bus.sel = 1'b0; bus.en = 1'b1;
        idle();
        xfer(1'b0, 17'h00009, 32'h0, rd, err, w, sc);
        model_xfer(1'b0, 17'h00009, 32'h0, exp_rd, exp_err);
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL abort_no_write got %h want %h", rd, exp_rd); end
        idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, exp_rd; logic err, exp_err, sc; int w;
        xfer(1'b1, 17'h00001, 32'h0000CAFE, rd, err, w, sc);
        model_xfer(1'b1, 17'h00001, 32'h0000CAFE, exp_rd, exp_err);
        checks++; if (w !== EXP_WAITS) begin failures++; $display("FAIL wait_write_waits got %0d want %0d", w, EXP_WAITS); end
        xfer(1'b0, 17'h00001, 32'h0, rd, err, w, sc);
        model_xfer(1'b0, 17'h00001, 32'h0, exp_rd, exp_err);
        checks++; if (w !== EXP_WAITS) begin failures++; $display("FAIL wait_read_waits got %0d want %0d", w, EXP_WAITS); end
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL wait_readback got %h want %h", rd, exp_rd); end
        idle();
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, exp_rd; logic err, exp_err, sc; int w;
        xfer(1'b1, 17'h00003, 32'h3C3C3C3C, rd, err, w, sc);
        model_xfer(1'b1, 17'h00003, 32'h3C3C3C3C, exp_rd, exp_err);
        xfer(1'b1, 17'h00044, 32'h44444444, rd, err, w, sc);
        model_xfer(1'b1, 17'h00044, 32'h44444444, exp_rd, exp_err);
        xfer(1'b0, 17'h00003, 32'h0, rd, err, w, sc);
        model_xfer(1'b0, 17'h00003, 32'h0, exp_rd, exp_err);
        idle();
        @(negedge clk);
        bus.sel = 1'b1; bus.en = 1'b0; bus.addr = 17'h00003; bus.wr_en = 1'b1; bus.wr_data = 32'hA5A5A5A5;
        @(negedge clk);
        bus.en = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL rst_mid_ready got %b want 0", bus.ready); end
        checks++; if (bus.rd_data !== 32'h0) begin failures++; $display("FAIL rst_mid_rd_data got %h want 0", bus.rd_data); end
        @(negedge clk);
        bus.sel = 1'b0; bus.en = 1'b0; bus.wr_en = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        xfer(1'b0, 17'h00003, 32'h0, rd, err, w, sc);
        model_xfer(1'b0, 17'h00003, 32'h0, exp_rd, exp_err);
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rst_abort_addr3 got %h want %h", rd, exp_rd); end
        xfer(1'b0, 17'h00044, 32'h0, rd, err, w, sc);
        model_xfer(1'b0, 17'h00044, 32'h0, exp_rd, exp_err);
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rst_clear_addr44 got %h want %h", rd, exp_rd); end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, d; logic err, exp_err, sc, wr; int w; logic [16:0] a;
        for (int i = 0; i < 80; i++) begin
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a = 17'($urandom_range(256, 131071));
                1, 2, 3: a = 17'($urandom_range(0, 7));
                default: a = 17'($urandom_range(0, 255));
            endcase
            d = $urandom;
            xfer(wr, a, d, rd, err, w, sc);
            model_xfer(wr, a, d, exp_rd, exp_err);
            checks++;
            if (rd !== exp_rd || err !== exp_err || w !== EXP_WAITS || !sc) begin
                failures++;
                $display("FAIL rand[%0d] wr=%b addr=%h rd got %h want %h err got %b want %b waits got %0d want %0d setup_clean %b",
                         i, wr, a, rd, exp_rd, err, exp_err, w, EXP_WAITS, sc);
            end
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_back_to_back();
        test_invalid();
        test_protocol_violation();
        test_abort();
        test_wait_states();
        test_reset_abort();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
